ether_frame_rx: RTL and testbench
=================================

Name: ether_frame_rx

Overview:
- Receive-side counterpart of the Ethernet TX packager.
- Consumes a continuous MSB-first dibit stream (RMII-style, already passed through bitorder) and finds preamble and SFD.
- Parses the 14-byte header (dest MAC, src MAC, ethertype), filters frames on dest MAC and ethertype, and emits payload bytes one per strobe for the downstream decoder-side buffer.
- FCS is not checked; trailing bytes are passed through as payload.

Parameters:
- MY_MAC, 48'hF00DDEADBEEF, accepted destination address.
- ETHERTYPE, 16'h0800, accepted ethertype.
- ACCEPT_BCAST, 1, also accept dest 48'hFFFFFFFFFFFF when 1.
- MIN_PRE_DIBITS, 8, minimum count of 2'b01 dibits required before the SFD.
- MAX_PAYLOAD, 1500, maximum payload bytes forwarded.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- axiiv  in  1  input dibit valid; high for the whole frame, low between frames
- axiid  in  2  input dibit, MSB-first (bits [7:6] of each byte first)
- axiov  out  1  one-cycle strobe: axiod holds a payload byte
- axiod  out  8  payload byte
- frame_start  out  1  one-cycle pulse when the header passes the filter
- frame_done  out  1  one-cycle pulse at end of an accepted frame
- frame_err  out  2  valid with frame_done: 0 ok, 1 truncated mid-byte, 2 oversize
- src_mac  out  48  source MAC of the last accepted frame; stable from frame_start until the next frame_start
- byte_count  out  11  payload bytes forwarded; valid with frame_done

Behaviour:
- Reset: all outputs 0, src_mac 0, state IDLE, all counters 0. Reset mid-frame abandons the frame with no frame_done; the receiver re-syncs on the next preamble.
- Dibits are sampled only on cycles with axiiv=1. An axiiv=0 cycle inside a frame ends the frame (see each state below).
- States:
  - IDLE: axiiv && axiid==01 -> PREAMBLE with pre_cnt=1. Any other valid dibit -> DROP.
  - PREAMBLE, dibit 01: pre_cnt++ (saturating).
  - PREAMBLE, dibit 11 with pre_cnt>=MIN_PRE_DIBITS: SFD first dibit seen; the next 3 dibits must be 01,01,01, then -> HEADER.
  - PREAMBLE, any other dibit, a bad SFD tail, or 11 with too few preamble dibits: -> DROP.
  - PREAMBLE, axiiv low: -> IDLE.
  - HEADER: shift 56 dibits into a 112-bit register, MSB first. After the 56th dibit compare: dest == MY_MAC, or (ACCEPT_BCAST and dest all-ones), and ethertype == ETHERTYPE.
    - Pass: latch src_mac, pulse frame_start next cycle, -> PAYLOAD.
    - Fail: -> DROP.
    - axiiv low in HEADER: -> IDLE, no pulses.
  - PAYLOAD: assemble bytes in a 4-dibit shift register.
    - On the 4th dibit: axiov=1 and axiod=byte on the next cycle (latency 1 cycle after the last dibit); byte_count++.
    - axiiv falls on a byte boundary: frame_done with err 0 the cycle after the first axiiv=0 cycle, then IDLE.
    - axiiv falls mid-byte: partial byte discarded, frame_done with err 1.
    - Byte MAX_PAYLOAD+1 completes: not emitted, -> DROP; on axiiv low, frame_done with err 2 and byte_count=MAX_PAYLOAD.
  - DROP: ignore input until axiiv=0, then -> IDLE. No outputs, except the oversize frame_done above.
- axiov never asserts outside PAYLOAD; frame_start precedes the first axiov by at least 3 cycles.
- byte_count saturates at MAX_PAYLOAD. It clears at frame_start and holds after frame_done.
- Back-to-back frames: a single axiiv=0 cycle between frames suffices; the IDLE entry and frame_done happen in that same gap.

Test Plan:
- 7x55, D5, dest F00DDEADBEEF, src 0x0123456789AB, type 0800, payload 00..09, axiiv low -> frame_start once; 10 axiov strobes with bytes 00..09; frame_done err 0, byte_count 10; src_mac 0x0123456789AB.
- Same frame with dest 0x112233445566 -> no frame_start, no axiov, no frame_done. Then dest FFFFFFFFFFFF -> accepted with ACCEPT_BCAST=1.
- Ethertype 0x86DD -> dropped. Preamble of only 3x01 dibits before SFD -> dropped. SFD 0xD4 -> dropped.
- 3 payload bytes then axiiv low after 2 dibits of the 4th byte -> 3 strobes; frame_done err 1, byte_count 3.
- 1501-byte payload -> 1500 strobes; frame_done err 2, byte_count 1500.
- Two valid frames separated by 1 idle cycle -> both fully delivered. rst asserted mid-payload -> outputs 0 next cycle, no frame_done; a following frame is received correctly.

Source files
------------

// File: rtl/ether_frame_rx_if.sv
// Dibit-in / payload-byte-out bundle between the RMII-style front end and the frame receiver.
// The slave modport is the receiver; the master modport is whatever feeds it and consumes its bytes.
interface ether_frame_rx_if;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [7:0]  axiod;
  logic        frame_start;
  logic        frame_done;
  logic [1:0]  frame_err;
  logic [47:0] src_mac;
  logic [10:0] byte_count;

  modport master (
    output axiiv, axiid,
    input  axiov, axiod, frame_start, frame_done, frame_err, src_mac, byte_count
  );

  modport slave (
    input  axiiv, axiid,
    output axiov, axiod, frame_start, frame_done, frame_err, src_mac, byte_count
  );
endinterface

// File: rtl/ether_frame_rx.sv
// Ethernet receive framer: finds preamble/SFD in an MSB-first dibit stream, filters on the
// header (dest MAC, ethertype) and forwards payload bytes one per strobe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | between frames, waiting for the first preamble dibit
// PREAMBLE | counting 01 dibits, waiting for the 11 that opens the SFD
// SFD      | checking the three 01 dibits that close the SFD
// HEADER   | shifting in the 56 header dibits, filter applied on the last
// PAYLOAD  | assembling and forwarding payload bytes
// DROP     | discarding the rest of the frame until axiiv falls
module ether_frame_rx #(
  parameter logic [47:0] MY_MAC         = 48'hF00DDEADBEEF,
  parameter logic [15:0] ETHERTYPE      = 16'h0800,
  parameter int          ACCEPT_BCAST   = 1,
  parameter int          MIN_PRE_DIBITS = 8,
  parameter int          MAX_PAYLOAD    = 1500
) (
  input logic             clk,
  input logic             rst,
  ether_frame_rx_if.slave bus
);

  localparam int PW = $clog2(MIN_PRE_DIBITS + 1);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, DROP
  } state_t;

  state_t         state;
  logic [PW-1:0]  pre_cnt;
  logic [1:0]     sfd_cnt;
  logic [5:0]     hdr_cnt;
  logic [109:0]   hdr;
  logic [1:0]     dib_cnt;
  logic [5:0]     byte_sr;
  logic           ovf;

  logic [111:0]   hdr_next;
  logic           dest_ok;
  logic           type_ok;

  // The filter looks at the header including the dibit arriving this cycle.
  assign hdr_next = {hdr, bus.axiid};
  assign dest_ok  = (hdr_next[111:64] == MY_MAC) ||
                    ((ACCEPT_BCAST != 0) && (&hdr_next[111:64]));
  assign type_ok  = (hdr_next[15:0] == ETHERTYPE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pre_cnt         <= '0;
      sfd_cnt         <= '0;
      hdr_cnt         <= '0;
      hdr             <= '0;
      dib_cnt         <= '0;
      byte_sr         <= '0;
      ovf             <= 1'b0;
      bus.axiov       <= 1'b0;
      bus.axiod       <= '0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.frame_err   <= '0;
      bus.src_mac     <= '0;
      bus.byte_count  <= '0;
    end else begin
      bus.axiov       <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.axiiv) begin
            if (bus.axiid == 2'b01) begin
              state   <= PREAMBLE;
              pre_cnt <= PW'(1);
            end else begin
              state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!bus.axiiv) begin
            state <= IDLE;
          end else if (bus.axiid == 2'b01) begin
            if (pre_cnt != PW'(MIN_PRE_DIBITS)) pre_cnt <= pre_cnt + PW'(1);
          end else if (bus.axiid == 2'b11 && pre_cnt >= PW'(MIN_PRE_DIBITS)) begin
            state   <= SFD;
            sfd_cnt <= '0;
          end else begin
            state <= DROP;
          end
        end
        SFD: begin
          if (!bus.axiiv) begin
            state <= IDLE;
          end else if (bus.axiid == 2'b01) begin
            if (sfd_cnt == 2'd2) begin
              state   <= HEADER;
              hdr_cnt <= '0;
            end else begin
              sfd_cnt <= sfd_cnt + 2'd1;
            end
          end else begin
            state <= DROP;
          end
        end
        HEADER: begin
          if (!bus.axiiv) begin
            state <= IDLE;
          end else begin
            hdr <= hdr_next[109:0];
            if (hdr_cnt == 6'd55) begin
              if (dest_ok && type_ok) begin
                state           <= PAYLOAD;
                bus.frame_start <= 1'b1;
                bus.src_mac     <= hdr_next[63:16];
                bus.byte_count  <= '0;
                dib_cnt         <= '0;
              end else begin
                state <= DROP;
              end
            end else begin
              hdr_cnt <= hdr_cnt + 6'd1;
            end
          end
        end
        PAYLOAD: begin
          if (!bus.axiiv) begin
            state          <= IDLE;
            bus.frame_done <= 1'b1;
            bus.frame_err  <= (dib_cnt == 2'd0) ? 2'd0 : 2'd1;
          end else begin
            byte_sr <= {byte_sr[3:0], bus.axiid};
            dib_cnt <= dib_cnt + 2'd1;
            if (dib_cnt == 2'd3) begin
              // One byte past the limit: swallow the remainder, report on the gap.
              if (bus.byte_count == 11'(MAX_PAYLOAD)) begin
                state <= DROP;
                ovf   <= 1'b1;
              end else begin
                bus.axiov      <= 1'b1;
                bus.axiod      <= {byte_sr, bus.axiid};
                bus.byte_count <= bus.byte_count + 11'd1;
              end
            end
          end
        end
        DROP: begin
          if (!bus.axiiv) begin
            state <= IDLE;
            ovf   <= 1'b0;
            if (ovf) begin
              bus.frame_done <= 1'b1;
              bus.frame_err  <= 2'd2;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ether_frame_rx.sv
// Bench for ether_frame_rx: frames are built as byte lists, the expected strobes/pulses are
// derived from the frame layout with cycle stamps, and one negedge process checks every cycle.
module tb_ether_frame_rx;

  localparam logic [47:0] MY_MAC = 48'hF00DDEADBEEF;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ether_frame_rx_if bus();

  ether_frame_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] b; } eb_t;
  typedef struct { int cyc; logic [47:0] src; } es_t;
  typedef struct { int cyc; logic [1:0] err; logic [10:0] cnt; } ed_t;

  eb_t eb_q[$];
  es_t es_q[$];
  ed_t ed_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          checking = 1'b0;
  int          n_strobe = 0;
  int          n_start  = 0;
  int          n_done   = 0;
  logic [1:0]  last_err = '0;
  logic [10:0] last_cnt = '0;
  logic [7:0]  rx_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] dd);
    @(posedge clk);
    #1;
    rst       = r;
    bus.axiiv = v;
    bus.axiid = dd;
  endtask

  task automatic clr();
    n_strobe = 0;
    n_start  = 0;
    n_done   = 0;
    last_err = '0;
    last_cnt = '0;
    rx_q.delete();
  endtask

  // Per-cycle compare against the stamped expectations.
  always @(negedge clk) begin
    if (checking) begin
      if (eb_q.size() > 0 && eb_q[0].cyc == cyc) begin
        check("axiov", 64'(bus.axiov), 64'(1));
        check("axiod", 64'(bus.axiod), 64'(eb_q[0].b));
        void'(eb_q.pop_front());
      end else begin
        check("axiov_quiet", 64'(bus.axiov), 64'(0));
      end
      if (es_q.size() > 0 && es_q[0].cyc == cyc) begin
        check("frame_start", 64'(bus.frame_start), 64'(1));
        check("src_mac", 64'(bus.src_mac), 64'(es_q[0].src));
        void'(es_q.pop_front());
      end else begin
        check("frame_start_quiet", 64'(bus.frame_start), 64'(0));
      end
      if (ed_q.size() > 0 && ed_q[0].cyc == cyc) begin
        check("frame_done", 64'(bus.frame_done), 64'(1));
        check("frame_err", 64'(bus.frame_err), 64'(ed_q[0].err));
        check("byte_count", 64'(bus.byte_count), 64'(ed_q[0].cnt));
        void'(ed_q.pop_front());
      end else begin
        check("frame_done_quiet", 64'(bus.frame_done), 64'(0));
      end
      if (bus.axiov) begin
        n_strobe++;
        rx_q.push_back(bus.axiod);
      end
      if (bus.frame_start) n_start++;
      if (bus.frame_done) begin
        n_done++;
        last_err = bus.frame_err;
        last_cnt = bus.byte_count;
      end
    end
  end

  // Drives one frame followed by `gap` idle cycles; abort_at >= 0 replaces that dibit with a reset.
  task automatic send_frame(input int n_pre, input logic [7:0] sfd, input logic [47:0] dest,
                            input logic [47:0] src, input logic [15:0] etype, input int n_pay,
                            input int extra, input int gap, input int abort_at, input bit seq_pay);
    logic [7:0] by[$];
    logic [1:0] d[$];
    logic [7:0] t;
    int c0, len, lim, n_fwd, hs;
    bit acc, aborted;
    by.push_back(sfd);
    for (int i = 0; i < 6; i++) by.push_back(dest[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) by.push_back(src[8*(5-i) +: 8]);
    by.push_back(etype[15:8]);
    by.push_back(etype[7:0]);
    for (int j = 0; j < n_pay; j++) by.push_back(seq_pay ? 8'(j) : 8'($urandom));
    for (int i = 0; i < n_pre; i++) d.push_back(2'b01);
    foreach (by[i]) begin
      t = by[i];
      for (int s = 3; s >= 0; s--) d.push_back(t[2*s +: 2]);
    end
    for (int e = 0; e < extra; e++) d.push_back(2'($urandom));
    len = d.size();
    c0  = cyc + 1;
    lim = (abort_at < 0) ? 32'h3FFFFFFF : c0 + abort_at;
    acc = (n_pre >= 8) && (sfd == 8'hD5) && (dest == MY_MAC || dest == BCAST) &&
          (etype == 16'h0800);
    if (acc) begin
      hs = c0 + n_pre + 60;
      if (hs <= lim) es_q.push_back('{hs, src});
      n_fwd = (n_pay > 1500) ? 1500 : n_pay;
      for (int j = 0; j < n_fwd; j++)
        if (hs + 4 + 4*j <= lim) eb_q.push_back('{hs + 4 + 4*j, by[15 + j]});
      if (c0 + len + 1 <= lim)
        ed_q.push_back('{c0 + len + 1, (n_pay > 1500) ? 2'd2 : (extra != 0) ? 2'd1 : 2'd0,
                         11'(n_fwd)});
    end
    aborted = 1'b0;
    for (int i = 0; i < len && !aborted; i++) begin
      if (i == abort_at) begin
        step(1'b1, 1'b0, 2'b00);
        aborted = 1'b1;
      end else begin
        step(1'b0, 1'b1, d[i]);
      end
    end
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    logic [47:0] rdest;
    logic [15:0] rtype;
    logic [7:0]  rsfd;
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    repeat (3) step(1'b1, 1'b0, 2'b00);
    repeat (2) step(1'b0, 1'b0, 2'b00);
    check("rst_axiov", 64'(bus.axiov), 64'(0));
    check("rst_axiod", 64'(bus.axiod), 64'(0));
    check("rst_frame_start", 64'(bus.frame_start), 64'(0));
    check("rst_frame_done", 64'(bus.frame_done), 64'(0));
    check("rst_frame_err", 64'(bus.frame_err), 64'(0));
    check("rst_src_mac", 64'(bus.src_mac), 64'(0));
    check("rst_byte_count", 64'(bus.byte_count), 64'(0));
    checking = 1'b1;

    // Reference frame: payload 00..09
    clr();
    send_frame(28, 8'hD5, MY_MAC, 48'h0123456789AB, 16'h0800, 10, 0, 3, -1, 1'b1);
    check("f1_starts", 64'(n_start), 64'(1));
    check("f1_strobes", 64'(n_strobe), 64'(10));
    for (int i = 0; i < 10; i++)
      check("f1_byte", 64'((i < rx_q.size()) ? rx_q[i] : 8'hEE), 64'(i));
    check("f1_dones", 64'(n_done), 64'(1));
    check("f1_err", 64'(last_err), 64'(0));
    check("f1_count", 64'(last_cnt), 64'(10));
    check("f1_src_mac", 64'(bus.src_mac), 64'h0123456789AB);

    clr();
    send_frame(28, 8'hD5, 48'h112233445566, 48'h0123456789AB, 16'h0800, 10, 0, 3, -1, 1'b1);
    check("wrong_dest_events", 64'(n_start + n_strobe + n_done), 64'(0));
    check("wrong_dest_src_hold", 64'(bus.src_mac), 64'h0123456789AB);

    clr();
    send_frame(28, 8'hD5, BCAST, 48'hA1A2A3A4A5A6, 16'h0800, 4, 0, 3, -1, 1'b1);
    check("bcast_starts", 64'(n_start), 64'(1));
    check("bcast_count", 64'(last_cnt), 64'(4));

    clr();
    send_frame(28, 8'hD5, MY_MAC, 48'h0123456789AB, 16'h86DD, 6, 0, 3, -1, 1'b1);
    send_frame(3, 8'hD5, MY_MAC, 48'h0123456789AB, 16'h0800, 6, 0, 3, -1, 1'b1);
    send_frame(28, 8'hD4, MY_MAC, 48'h0123456789AB, 16'h0800, 6, 0, 3, -1, 1'b1);
    check("drops_events", 64'(n_start + n_strobe + n_done), 64'(0));

    clr();
    send_frame(28, 8'hD5, MY_MAC, 48'h0123456789AB, 16'h0800, 3, 2, 3, -1, 1'b1);
    check("trunc_strobes", 64'(n_strobe), 64'(3));
    check("trunc_err", 64'(last_err), 64'(1));
    check("trunc_count", 64'(last_cnt), 64'(3));

    clr();
    send_frame(8, 8'hD5, MY_MAC, 48'h0123456789AB, 16'h0800, 1501, 0, 3, -1, 1'b0);
    check("big_strobes", 64'(n_strobe), 64'(1500));
    check("big_err", 64'(last_err), 64'(2));
    check("big_count", 64'(last_cnt), 64'(1500));

    clr();
    send_frame(28, 8'hD5, MY_MAC, 48'h111111111111, 16'h0800, 5, 0, 1, -1, 1'b1);
    send_frame(28, 8'hD5, MY_MAC, 48'h222222222222, 16'h0800, 7, 0, 3, -1, 1'b1);
    check("b2b_dones", 64'(n_done), 64'(2));
    check("b2b_strobes", 64'(n_strobe), 64'(12));

    clr();
    send_frame(28, 8'hD5, MY_MAC, 48'h333333333333, 16'h0800, 10, 0, 1, 28 + 60 + 21, 1'b1);
    check("rst_mid_axiov", 64'(bus.axiov), 64'(0));
    check("rst_mid_src_mac", 64'(bus.src_mac), 64'(0));
    check("rst_mid_byte_count", 64'(bus.byte_count), 64'(0));
    check("rst_mid_strobes", 64'(n_strobe), 64'(5));
    check("rst_mid_dones", 64'(n_done), 64'(0));
    clr();
    send_frame(28, 8'hD5, MY_MAC, 48'h444444444444, 16'h0800, 6, 0, 3, -1, 1'b1);
    check("after_rst_dones", 64'(n_done), 64'(1));
    check("after_rst_count", 64'(last_cnt), 64'(6));
    check("after_rst_src_mac", 64'(bus.src_mac), 64'h444444444444);

    repeat (40) begin
      case ($urandom_range(0, 3))
        0:       rdest = BCAST;
        1:       rdest = {16'($urandom), 32'($urandom)};
        default: rdest = MY_MAC;
      endcase
      rtype = ($urandom_range(0, 4) == 0) ? 16'h86DD : 16'h0800;
      rsfd  = ($urandom_range(0, 7) == 0) ? 8'hD4 : 8'hD5;
      send_frame(int'($urandom_range(6, 20)), rsfd, rdest, {16'($urandom), 32'($urandom)},
                 rtype, int'($urandom_range(0, 40)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 int'($urandom_range(1, 3)), -1, 1'b0);
    end
    repeat (4) step(1'b0, 1'b0, 2'b00);
    check("pending_expectations", 64'(eb_q.size() + es_q.size() + ed_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
